block_retirer: RTL and testbench
================================

Name: block_retirer

Overview:
- Sits directly downstream of the instruction-type detector in the CVA6 trace-encoder connector.
- Consumes one committed instruction per cycle, together with its itype, address and size.
- Groups sequentially retired instructions into E-Trace retirement blocks and emits one block record (start iaddr, iretire, ilastsize, itype) per closing event.
- Records go through a 2-entry output buffer with valid/ready handshake toward the packet emitter.

Parameters:
XLEN, 64, instruction address width
ITYPE_LEN, 3, itype width; must match the detector
IRETIRE_LEN, 32, width of the retired half-word count

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  an instruction commits this cycle
iaddr_i  in  XLEN  address of the committing instruction
itype_i  in  ITYPE_LEN  type from the detector; 1/2 (exception/interrupt) may arrive with valid_i=0
compressed_i  in  1  committing instruction is 16-bit
valid_o  out  1  block record available
ready_i  in  1  consumer accepts the record
iaddr_o  out  XLEN  address of the first instruction in the block
iretire_o  out  IRETIRE_LEN  half-words retired in the block
ilastsize_o  out  1  size of the last instruction: 0 = 16-bit, 1 = 32-bit
itype_o  out  ITYPE_LEN  closing type; 0 = forced close on saturation
overflow_o  out  1  one-cycle pulse when a record is dropped

Behaviour:
- Reset values:
  - valid_o=0, overflow_o=0.
  - All record outputs 0.
  - FSM in IDLE, count_q=0, last_iaddr_q=0, buffer empty.
  - Reset mid-operation discards the open block and all buffered records, with no output.
- Size of a committing instruction: sz = 1 if compressed_i, else 2.
- Block FSM, IDLE state:
  - valid_i=1, itype_i=0: start_q=iaddr_i, count_q=sz, lastsz_q=~compressed_i, go to OPEN.
  - valid_i=1, itype_i!=0: close immediately with {iaddr_i, sz, ~compressed_i, itype_i}. Stay in IDLE.
  - valid_i=0, itype_i in {1,2}: close with {last_iaddr_q, 0, 0, itype_i}.
- Block FSM, OPEN state:
  - valid_i=1, itype_i=0: count_q += sz and update lastsz_q.
    - If the new count is >= 2^IRETIRE_LEN-2, force a close with itype 0 and go to IDLE.
  - valid_i=1, itype_i!=0: close with {start_q, count_q+sz, ~compressed_i, itype_i}. Go to IDLE.
  - valid_i=0, itype_i in {1,2}: close with {start_q, count_q, lastsz_q, itype_i}. Go to IDLE.
  - valid_i=0, itype_i=0: hold.
- last_iaddr_q updates to iaddr_i on every valid_i.
- itype_i values other than 1/2 with valid_i=0 are ignored.
- Latency: a record closed in cycle N is presented on valid_o in cycle N+1 if the buffer was empty.
- Output buffer: 2-entry FIFO, in order.
  - Head drives the outputs.
  - Pop on valid_o & ready_i.
  - Push and pop in the same cycle are allowed, including when full.
  - Outputs hold stable while valid_o=1 and ready_i=0.
- Full with no pop: the new record is dropped, overflow_o=1 for one cycle, FSM still transitions normally.
- Commit is never stalled; the block has no ready output upstream.

Test Plan:
- Reset then commits 0x8000 (32-bit), 0x8004 (16-bit), 0x8006 (32-bit, itype 5), ready_i=1 -> one record {0x8000, iretire=5, ilastsize=1, itype=5} with valid_o one cycle after the third commit.
- IDLE, single commit 0x100 compressed with itype 4 -> record {0x100, 1, 0, 4}; FSM stays IDLE.
- OPEN with count 6 (last at 0x20C, 32-bit), then valid_i=0 and itype_i=2 -> record {start, 6, 1, 2}; a following interrupt in IDLE -> record {0x20C, 0, 0, 2}.
- ready_i=0 and three closing events -> first two held in order with stable outputs, third drops with overflow_o=1 for exactly one cycle; raise ready_i -> both records drain, valid_o falls.
- IRETIRE_LEN=4 and eight 32-bit commits with itype 0 -> forced close {start, 14, 1, 0} at the 7th commit; the 8th commit opens a new block.
- Assert rst_i while OPEN and with one buffered record -> next cycle valid_o=0; a subsequent commit starts a fresh block at its own address.

Source files
------------

// File: rtl/block_retirer.sv
// ============================================================================
// block_retirer: groups retired instructions into E-Trace retirement blocks
// and queues the closed block records in a 2-entry output FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_retirer #(
  parameter int XLEN        = 64,
  parameter int ITYPE_LEN   = 3,
  parameter int IRETIRE_LEN = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic [ITYPE_LEN-1:0]   itype_i,
  input  logic                   compressed_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [XLEN-1:0]        iaddr_o,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic                   ilastsize_o,
  output logic [ITYPE_LEN-1:0]   itype_o,
  output logic                   overflow_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  localparam int REC_W = XLEN + IRETIRE_LEN + 1 + ITYPE_LEN;
  localparam logic [ITYPE_LEN-1:0]   ITYPE_EXC = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0]   ITYPE_INT = ITYPE_LEN'(2);
  // Saturation threshold 2^IRETIRE_LEN - 2 keeps count+2 inside the counter.
  localparam logic [IRETIRE_LEN-1:0] SAT_LIMIT = {{(IRETIRE_LEN-1){1'b1}}, 1'b0};

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        start_q, start_d;
  logic [IRETIRE_LEN-1:0] count_q, count_d;
  logic                   lastsz_q, lastsz_d;
  logic [XLEN-1:0]        last_iaddr_q, last_iaddr_d;

  logic [REC_W-1:0]       mem_q [0:1];
  logic [REC_W-1:0]       mem_d [0:1];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   overflow_q, overflow_d;

  logic [IRETIRE_LEN-1:0] sz;
  logic [IRETIRE_LEN-1:0] sum;
  logic                   is_trap;
  logic                   rec_vld;
  logic [REC_W-1:0]       rec;
  logic                   pop, push, full;
  logic [REC_W-1:0]       head;

  // Block tracking FSM and record formation.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    count_d      = count_q;
    lastsz_d     = lastsz_q;
    last_iaddr_d = last_iaddr_q;
    rec_vld      = 1'b0;
    rec          = '0;

    sz      = compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    sum     = count_q + sz;
    is_trap = (itype_i == ITYPE_EXC) || (itype_i == ITYPE_INT);

    if (valid_i) begin
      last_iaddr_d = iaddr_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (itype_i == '0) begin
            start_d  = iaddr_i;
            count_d  = sz;
            lastsz_d = ~compressed_i;
            state_d  = ST_OPEN;
          end else begin
            rec_vld = 1'b1;
            rec     = {iaddr_i, sz, ~compressed_i, itype_i};
          end
        end else if (is_trap) begin
          rec_vld = 1'b1;
          rec     = {last_iaddr_q, {IRETIRE_LEN{1'b0}}, 1'b0, itype_i};
        end
      end
      ST_OPEN: begin
        if (valid_i) begin
          if (itype_i == '0) begin
            count_d  = sum;
            lastsz_d = ~compressed_i;
            if (sum >= SAT_LIMIT) begin
              rec_vld = 1'b1;
              rec     = {start_q, sum, ~compressed_i, {ITYPE_LEN{1'b0}}};
              count_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            rec_vld = 1'b1;
            rec     = {start_q, sum, ~compressed_i, itype_i};
            count_d = '0;
            state_d = ST_IDLE;
          end
        end else if (is_trap) begin
          rec_vld = 1'b1;
          rec     = {start_q, count_q, lastsz_q, itype_i};
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output FIFO; a push into a full FIFO is accepted only when the head leaves.
  always_comb begin
    full       = (cnt_q == 2'd2);
    pop        = (cnt_q != 2'd0) && ready_i;
    push       = rec_vld && (!full || pop);
    overflow_d = rec_vld && full && !pop;

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) begin
      mem_d[wr_ptr_q] = rec;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      start_q      <= '0;
      count_q      <= '0;
      lastsz_q     <= 1'b0;
      last_iaddr_q <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      count_q      <= count_d;
      lastsz_q     <= lastsz_d;
      last_iaddr_q <= last_iaddr_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    valid_o    = (cnt_q != 2'd0);
    overflow_o = overflow_q;
    head       = valid_o ? mem_q[rd_ptr_q] : '0;
    {iaddr_o, iretire_o, ilastsize_o, itype_o} = head;
  end

endmodule

`default_nettype wire

// File: tb/tb_block_retirer.sv
// Directed bench for block_retirer: default instance plus a narrow-counter
// instance for the saturation case.
`default_nettype none

module tb_block_retirer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [63:0] iaddr = '0;
  logic [2:0]  itype = '0;
  logic        compressed = 1'b0;
  logic        ready = 1'b1;
  logic        valid_o;
  logic [63:0] iaddr_o;
  logic [31:0] iretire_o;
  logic        ilast_o;
  logic [2:0]  itype_o;
  logic        ovf_o;

  logic        v4 = 1'b0;
  logic [63:0] a4 = '0;
  logic [2:0]  t4 = '0;
  logic        c4 = 1'b0;
  logic        vo4;
  logic [63:0] ao4;
  logic [3:0]  ro4;
  logic        lo4;
  logic [2:0]  to4;
  logic        ovf4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  block_retirer dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .iaddr_i(iaddr), .itype_i(itype),
    .compressed_i(compressed), .valid_o(valid_o), .ready_i(ready), .iaddr_o(iaddr_o),
    .iretire_o(iretire_o), .ilastsize_o(ilast_o), .itype_o(itype_o), .overflow_o(ovf_o)
  );

  block_retirer #(.XLEN(64), .ITYPE_LEN(3), .IRETIRE_LEN(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .iaddr_i(a4), .itype_i(t4),
    .compressed_i(c4), .valid_o(vo4), .ready_i(1'b1), .iaddr_o(ao4),
    .iretire_o(ro4), .ilastsize_o(lo4), .itype_o(to4), .overflow_o(ovf4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [63:0] a, input logic [31:0] r,
                           input logic l, input logic [2:0] t);
    check({tag, ".valid"}, 64'(valid_o), 64'd1);
    check({tag, ".iaddr"}, iaddr_o, a);
    check({tag, ".iretire"}, 64'(iretire_o), 64'(r));
    check({tag, ".ilast"}, 64'(ilast_o), 64'(l));
    check({tag, ".itype"}, 64'(itype_o), 64'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic c, input logic [2:0] t);
    valid = v; iaddr = a; compressed = c; itype = t;
    step();
  endtask

  initial begin
    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst.valid", 64'(valid_o), 64'd0);
    check("rst.ovf", 64'(ovf_o), 64'd0);
    check("rst.iaddr", iaddr_o, 64'd0);
    check("rst.iretire", 64'(iretire_o), 64'd0);
    check("rst.itype", 64'(itype_o), 64'd0);

    // Basic block: 32b, 16b, 32b closing with itype 5
    drive(1, 64'h8000, 0, 0);
    drive(1, 64'h8004, 1, 0);
    check("blk.pre", 64'(valid_o), 64'd0);
    drive(1, 64'h8006, 0, 5);
    check_rec("blk", 64'h8000, 5, 1, 5);
    drive(0, 0, 0, 0);
    check("blk.drain", 64'(valid_o), 64'd0);

    // Immediate close from IDLE, then a trap proves FSM stayed IDLE
    drive(1, 64'h100, 1, 4);
    check_rec("idle_close", 64'h100, 1, 0, 4);
    drive(0, 0, 0, 1);
    check_rec("idle_exc", 64'h100, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("idle.drain", 64'(valid_o), 64'd0);

    // Open block of 6, ignored itype while idle-cycling, interrupt closes
    drive(1, 64'h204, 0, 0);
    drive(0, 0, 0, 3);
    check("open.ign", 64'(valid_o), 64'd0);
    drive(1, 64'h208, 0, 0);
    drive(1, 64'h20C, 0, 0);
    drive(0, 0, 0, 0);
    check("open.hold", 64'(valid_o), 64'd0);
    drive(0, 0, 0, 2);
    check_rec("open_int", 64'h204, 6, 1, 2);
    drive(0, 0, 0, 2);
    check_rec("idle_int", 64'h20C, 0, 0, 2);
    drive(0, 0, 0, 0);

    // Back-pressure, overflow drop, drain in order
    ready = 1'b0;
    drive(1, 64'h300, 0, 4);
    check_rec("bp1", 64'h300, 2, 1, 4);
    drive(1, 64'h310, 1, 6);
    check_rec("bp2", 64'h300, 2, 1, 4);
    check("bp2.ovf", 64'(ovf_o), 64'd0);
    drive(1, 64'h320, 0, 3);
    check("bp3.ovf", 64'(ovf_o), 64'd1);
    check_rec("bp3", 64'h300, 2, 1, 4);
    drive(0, 0, 0, 0);
    check("bp4.ovf", 64'(ovf_o), 64'd0);
    check_rec("bp4", 64'h300, 2, 1, 4);
    ready = 1'b1;
    step();
    check_rec("drain1", 64'h310, 1, 0, 6);
    step();
    check("drain2.valid", 64'(valid_o), 64'd0);

    // Saturation on the 4-bit counter instance
    for (int i = 0; i < 8; i++) begin
      v4 = 1'b1; a4 = 64'h400 + 64'(4 * i); c4 = 1'b0; t4 = '0;
      step();
      if (i == 5) check("sat.pre", 64'(vo4), 64'd0);
      if (i == 6) begin
        check("sat.valid", 64'(vo4), 64'd1);
        check("sat.iaddr", ao4, 64'h400);
        check("sat.iretire", 64'(ro4), 64'd14);
        check("sat.ilast", 64'(lo4), 64'd1);
        check("sat.itype", 64'(to4), 64'd0);
      end
    end
    check("sat.drain", 64'(vo4), 64'd0);
    v4 = 1'b0; t4 = 3'd1;
    step();
    check("sat.new.iaddr", ao4, 64'h41C);
    check("sat.new.iretire", 64'(ro4), 64'd2);
    t4 = '0;

    // Reset with an open block and a buffered record
    ready = 1'b0;
    drive(1, 64'h500, 0, 4);
    drive(1, 64'h600, 0, 0);
    check_rec("pre_rst", 64'h500, 2, 1, 4);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
    check("rst2.valid", 64'(valid_o), 64'd0);
    check("rst2.iaddr", iaddr_o, 64'd0);
    drive(1, 64'h700, 1, 0);
    check("rst2.open", 64'(valid_o), 64'd0);
    drive(0, 0, 0, 1);
    check_rec("post_rst", 64'h700, 1, 0, 1);
    ready = 1'b1;
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
